// File: rtl/multicycle_fsm.sv
// multicycle_fsm -- Moore control FSM for a multicycle ARM-style datapath.
//
// Purpose:
//   Steps each instruction through FETCH/DECODE and then a memory, data
//   processing or branch path, driving one control word per state. The
//   control word depends only on the current state. The exceptions are
//   the memory handshake qualifiers and the DECODE-stage NOP done flag.
//
// Configuration:
//   MEM_WAIT_EN -- when defined, adds the mem_ready input. FETCH, MEMRD and
//   MEMWR then hold until memory reports completion. When undefined, the
//   port is absent and memory is treated as always ready.
//
// Ports:
//   clk        in   1  sole clock, rising edge
//   reset      in   1  synchronous, active-low
//   Op         in   2  Instr[27:26]
//   Funct      in   6  Instr[25:20]; Funct[5]=I bit, Funct[0]=L/S bit
//   mem_ready  in   1  memory access complete (MEM_WAIT_EN only)
//   IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp,
//   instr_done out 1 each
//   ALUSrcB, ResultSrc out 2 each
//   state      out  4  current state encoding
module multicycle_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       instr_done,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t state_r, state_n;

`ifndef MEM_WAIT_EN
  // Without the handshake, every memory access completes in one cycle.
  logic mem_ready;
  assign mem_ready = 1'b1;
`endif

  // Only the I bit and the L/S bit steer the sequence; the rest of Funct
  // belongs to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register. Reset wins on any edge, even mid-instruction.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= FETCH;
    else        state_r <= state_n;
  end

  // Next-state and Moore control decode. Unused encodings fall back to FETCH.
  // While reset is held, present the FETCH datapath setup with every
  // side-effecting strobe suppressed.
  always_comb begin
    state_n    = FETCH;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    ALUOp      = 1'b0;
    instr_done = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;

    case (state_r)
      FETCH:  state_n = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b01:   state_n = MEMADR;
          2'b00:   state_n = Funct[5] ? EXECI : EXECR;
          2'b10:   state_n = BRANCH;
          default: state_n = FETCH;
        endcase
      end
      MEMADR: state_n = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_n = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_n = mem_ready ? FETCH : MEMWR;
      EXECR:  state_n = ALUWB;
      EXECI:  state_n = ALUWB;
      default: state_n = FETCH;
    endcase

    if (!reset) begin
      ALUSrcA   = 1'b1;
      ALUSrcB   = 2'b10;
      ResultSrc = 2'b10;
    end else begin
      case (state_r)
        FETCH: begin
          // The instruction is latched and the PC advances only once the
          // fetch actually completes.
          IRWrite   = mem_ready;
          NextPC    = mem_ready;
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        DECODE: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ResultSrc  = 2'b10;
          instr_done = (Op == 2'b11);
        end
        MEMADR: ALUSrcB = 2'b01;
        MEMRD:  AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc  = 2'b01;
          RegW       = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          // The write request stays asserted for the whole wait, but the
          // instruction retires only on the completing cycle.
          AdrSrc     = 1'b1;
          MemW       = 1'b1;
          instr_done = mem_ready;
        end
        EXECR:  ALUOp = 1'b1;
        EXECI: begin
          ALUSrcB = 2'b01;
          ALUOp   = 1'b1;
        end
        ALUWB: begin
          RegW       = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcB    = 2'b01;
          ResultSrc  = 2'b10;
          Branch     = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_r;

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-003 SHALL have port: Op  input  2  Instr[27:26] from instruction register.
REQ-004 SHALL have port: Funct  input  6  Instr[25:20]; Funct[5]=I bit, Funct[0]=L/S bit.
REQ-005 SHALL have port: mem_ready  input  1  memory access complete; present only under MEM_WAIT_EN.
REQ-006 SHALL have outputs, 1 bit each: IRWrite, AdrSrc (0=PC, 1=ALUOut), ALUSrcA (0=Rn, 1=PC), NextPC, RegW, MemW, Branch, ALUOp (1=decode Funct), instr_done (last cycle of instruction).
REQ-007 SHALL have outputs, 2 bits each: ALUSrcB (00=reg, 01=ExtImm, 10=const 4), ResultSrc (00=ALUOut, 01=Data, 10=ALUResult).
REQ-008 SHALL have output: state  4 bits  current state encoding, for debug and bench.

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-010 SHALL transition FETCH->DECODE unconditionally.
REQ-011 SHALL transition from DECODE by Op: 01->MEMADR; 00 with Funct[5]=0->EXECR; 00 with Funct[5]=1->EXECI; 10->BRANCH; 11->FETCH (treated as NOP).
REQ-012 SHALL transition MEMADR->MEMRD if Funct[0]=1, else ->MEMWR.
REQ-013 SHALL transition MEMRD->MEMWB, EXECR->ALUWB and EXECI->ALUWB; MEMWB, MEMWR, ALUWB and BRANCH SHALL each go to FETCH.
REQ-014 SHALL drive outputs as Moore decode of state; any field not listed below is 0.
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECR: ALUOp=1.
- EXECI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-015 SHALL assert instr_done in MEMWB, MEMWR, ALUWB, BRANCH, and in DECODE when Op=11.
REQ-016 SHALL leave condition evaluation to downstream logic; RegW/MemW/Branch are unconditioned requests.
REQ-017 SHALL give latency in cycles: LDR 5, STR 4, data-processing 4, B 3, Op=11 2.

Reset
REQ-018 SHALL load state=FETCH on any rising edge where reset=0, regardless of current state, including mid-instruction.
REQ-019 SHALL force IRWrite, NextPC, RegW, MemW, Branch and instr_done to 0 while reset=0; the other outputs SHALL carry FETCH values.
REQ-020 SHALL, on the first edge with reset=1, perform FETCH with IRWrite=1 and NextPC=1.

Configuration
REQ-021 SHALL support macro MEM_WAIT_EN. When defined: mem_ready port exists; FETCH, MEMRD and MEMWR hold while mem_ready=0.
- In FETCH, IRWrite and NextPC assert only in the cycle mem_ready=1.
- MemW stays high throughout MEMWR.
- instr_done in MEMWR is qualified by mem_ready.
REQ-022 SHALL, when MEM_WAIT_EN is undefined, omit the mem_ready port and behave as if mem_ready=1.

Verification
REQ-023 SHALL cover LDR: Op=01, Funct=011001 -> state 0,1,2,3,4,0; RegW=1 and ResultSrc=01 only in cycle 5; instr_done cycle 5.
REQ-024 SHALL cover STR: Funct=011000 -> state 0,1,2,5,0; MemW=1 and AdrSrc=1 only in cycle 4.
REQ-025 SHALL cover data-processing: Op=00, Funct=101000 -> 0,1,7,8,0 with ALUSrcB=01, ALUOp=1 in state 7; Funct=001000 -> 0,1,6,8,0 with ALUSrcB=00.
REQ-026 SHALL cover branch and NOP: Op=10 -> 0,1,9,0, Branch=1 in cycle 3; Op=11 -> 0,1,0, instr_done in DECODE.
REQ-027 SHALL cover reset mid-instruction: reset=0 asserted in state 3 -> state=0 next edge; RegW, MemW, NextPC are 0 while reset=0.
REQ-028 SHALL cover MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH -> state stays 0 for 4 cycles and exactly one IRWrite/NextPC pulse occurs; mem_ready=0 for 2 cycles in MEMWR -> MemW high for 3 cycles, single instr_done.
